// File: rtl/small_fifo_fwft.sv
// rtl/small_fifo_fwft.sv - parametrised small FIFO with optional first-word-fall-through output
// Count-based flags, protected overflow/underflow with one-cycle error pulses.
module small_fifo_fwft #(
  parameter int WIDTH                = 72,
  parameter int MAX_DEPTH_BITS       = 3,
  parameter int PROG_FULL_THRESHOLD  = 2**MAX_DEPTH_BITS - 1,
  parameter int PROG_EMPTY_THRESHOLD = 1,
  parameter bit FWFT                 = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    nearly_full,
  output logic                    prog_full,
  output logic                    empty,
  output logic                    prog_empty,
  output logic [MAX_DEPTH_BITS:0] count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
  localparam int CW        = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0]             DEPTH_C   = CW'(MAX_DEPTH);
  localparam logic [CW-1:0]             PFULL_C   = CW'(PROG_FULL_THRESHOLD);
  localparam logic [CW-1:0]             PEMPTY_C  = CW'(PROG_EMPTY_THRESHOLD);
  localparam logic [CW-1:0]             CNT_ONE   = CW'(1);
  localparam logic [MAX_DEPTH_BITS-1:0] PTR_ONE   = MAX_DEPTH_BITS'(1);

  logic [WIDTH-1:0]          mem [MAX_DEPTH];
  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr_nxt;
  logic                      acc_wr;
  logic                      acc_rd;

  assign full        = (count == DEPTH_C);
  assign nearly_full = (count >= (DEPTH_C - CNT_ONE));
  assign prog_full   = (count >= PFULL_C);
  assign empty       = (count == '0);
  assign prog_empty  = (count <= PEMPTY_C);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write alongside it.
  assign acc_rd     = rd_en & ~empty;
  assign acc_wr     = wr_en & (~full | acc_rd);
  assign rd_ptr_nxt = rd_ptr + PTR_ONE;

  always_ff @(posedge clk) begin
    if (acc_wr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (acc_wr) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (acc_rd) begin
        rd_ptr <= rd_ptr_nxt;
      end
      case ({acc_wr, acc_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      overflow  <= wr_en & full & ~acc_rd;
      underflow <= rd_en & empty;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // dout mirrors the head entry; the head stays in mem, so capacity is MAX_DEPTH overall.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout <= '0;
        end else if (acc_rd) begin
          if (count > CNT_ONE) begin
            dout <= mem[rd_ptr_nxt];
          end else if (acc_wr) begin
            dout <= din;
          end
        end else if (acc_wr && empty) begin
          dout <= din;
        end
      end
    end else begin : g_std
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          dout <= '0;
        end else if (acc_rd) begin
          dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_small_fifo_fwft.sv
// tb/tb_small_fifo_fwft.sv - directed bench for small_fifo_fwft in FWFT and standard modes
module tb_small_fifo_fwft;

  logic       clk;
  logic       reset;

  logic [7:0] f_din;
  logic       f_wr;
  logic       f_rd;
  logic [7:0] f_dout;
  logic       f_full, f_nearly_full, f_prog_full, f_empty, f_prog_empty;
  logic [3:0] f_count;
  logic       f_overflow, f_underflow;

  logic [7:0] s_din;
  logic       s_wr;
  logic       s_rd;
  logic [7:0] s_dout;
  logic       s_full, s_nearly_full, s_prog_full, s_empty, s_prog_empty;
  logic [3:0] s_count;
  logic       s_overflow, s_underflow;

  int ncmp;
  int nfail;

  small_fifo_fwft #(.WIDTH(8), .MAX_DEPTH_BITS(3), .FWFT(1'b1)) u_fwft (
    .clk(clk), .reset(reset), .din(f_din), .wr_en(f_wr), .rd_en(f_rd),
    .dout(f_dout), .full(f_full), .nearly_full(f_nearly_full), .prog_full(f_prog_full),
    .empty(f_empty), .prog_empty(f_prog_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  small_fifo_fwft #(.WIDTH(8), .MAX_DEPTH_BITS(3), .FWFT(1'b0)) u_std (
    .clk(clk), .reset(reset), .din(s_din), .wr_en(s_wr), .rd_en(s_rd),
    .dout(s_dout), .full(s_full), .nearly_full(s_nearly_full), .prog_full(s_prog_full),
    .empty(s_empty), .prog_empty(s_prog_empty), .count(s_count),
    .overflow(s_overflow), .underflow(s_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] q[$];
  logic [7:0] m_dout;
  logic       r_wr, r_rd, m_empty, m_full, m_ar, m_aw, e_ov, e_un;
  int         writes;

  initial begin
    ncmp  = 0;
    nfail = 0;
    reset = 1'b1;
    f_din = '0; f_wr = 1'b0; f_rd = 1'b0;
    s_din = '0; s_wr = 1'b0; s_rd = 1'b0;
    tick();
    tick();

    chk("rst_count", 32'(f_count), 32'd0);
    chk("rst_empty", 32'(f_empty), 32'd1);
    chk("rst_prog_empty", 32'(f_prog_empty), 32'd1);
    chk("rst_flags", {29'd0, f_full, f_nearly_full, f_prog_full}, 32'd0);
    chk("rst_pulses", {30'd0, f_overflow, f_underflow}, 32'd0);
    chk("rst_dout", 32'(f_dout), 32'd0);
    chk("rst_std_empty", 32'(s_empty), 32'd1);
    reset = 1'b0;

    // mid-stream async reset with five words held
    for (int i = 1; i <= 5; i++) begin
      f_din = 8'(i); f_wr = 1'b1;
      tick();
    end
    f_wr = 1'b0;
    chk("pre_rst_count", 32'(f_count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", 32'(f_count), 32'd0);
    chk("async_rst_empty", 32'(f_empty), 32'd1);
    chk("async_rst_prog_empty", 32'(f_prog_empty), 32'd1);
    chk("async_rst_dout", 32'(f_dout), 32'd0);
    #1;
    reset = 1'b0;

    // FWFT back-to-back writes then reads
    f_wr = 1'b1; f_din = 8'h11;
    tick();
    chk("fwft_first_dout", 32'(f_dout), 32'h11);
    chk("fwft_first_empty", 32'(f_empty), 32'd0);
    f_din = 8'h22;
    tick();
    f_din = 8'h33;
    tick();
    f_wr = 1'b0;
    chk("fwft_count3", 32'(f_count), 32'd3);
    chk("fwft_head_hold", 32'(f_dout), 32'h11);
    f_rd = 1'b1;
    tick();
    chk("fwft_rd1", 32'(f_dout), 32'h22);
    tick();
    chk("fwft_rd2", 32'(f_dout), 32'h33);
    tick();
    f_rd = 1'b0;
    chk("fwft_drained_empty", 32'(f_empty), 32'd1);
    chk("fwft_stale_dout", 32'(f_dout), 32'h33);

    // standard mode: dout loads on the read edge
    s_wr = 1'b1; s_din = 8'hA5;
    tick();
    s_wr = 1'b0;
    chk("std_wr_empty", 32'(s_empty), 32'd0);
    chk("std_wr_dout", 32'(s_dout), 32'd0);
    s_rd = 1'b1;
    tick();
    chk("std_rd_dout", 32'(s_dout), 32'hA5);
    chk("std_rd_empty", 32'(s_empty), 32'd1);
    tick();
    s_rd = 1'b0;
    chk("std_underflow", 32'(s_underflow), 32'd1);
    chk("std_underflow_dout", 32'(s_dout), 32'hA5);

    // fill to capacity, flags and overflow
    for (int i = 0; i < 8; i++) begin
      f_din = 8'(i); f_wr = 1'b1;
      tick();
      if (i == 5) begin
        chk("fill6_nearly_full", 32'(f_nearly_full), 32'd0);
        chk("fill6_prog_full", 32'(f_prog_full), 32'd0);
      end
      if (i == 6) begin
        chk("fill7_nearly_full", 32'(f_nearly_full), 32'd1);
        chk("fill7_prog_full", 32'(f_prog_full), 32'd1);
        chk("fill7_full", 32'(f_full), 32'd0);
      end
      if (i == 7) chk("fill8_full", 32'(f_full), 32'd1);
    end
    f_din = 8'h08;
    tick();
    f_wr = 1'b0;
    chk("ovf_pulse", 32'(f_overflow), 32'd1);
    chk("ovf_count", 32'(f_count), 32'd8);
    tick();
    chk("ovf_clear", 32'(f_overflow), 32'd0);
    f_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", 32'(f_dout), 32'(i));
      if (i == 6) chk("drain_prog_empty_cnt2", 32'(f_prog_empty), 32'd0);
      if (i == 7) chk("drain_prog_empty_cnt1", 32'(f_prog_empty), 32'd1);
      tick();
    end
    f_rd = 1'b0;
    chk("drain_empty", 32'(f_empty), 32'd1);
    chk("drain_no_underflow", 32'(f_underflow), 32'd0);

    // full with simultaneous write and read
    for (int i = 0; i < 8; i++) begin
      f_din = 8'(8'h40 + i); f_wr = 1'b1;
      tick();
    end
    f_rd = 1'b1; f_din = 8'h99;
    tick();
    f_wr = 1'b0;
    chk("full_wr_rd_count", 32'(f_count), 32'd8);
    chk("full_wr_rd_ovf", 32'(f_overflow), 32'd0);
    chk("full_wr_rd_full", 32'(f_full), 32'd1);
    for (int i = 1; i < 8; i++) begin
      chk("full_wr_rd_data", 32'(f_dout), 32'(8'h40 + i));
      tick();
    end
    chk("full_wr_rd_last", 32'(f_dout), 32'h99);
    tick();
    f_rd = 1'b0;
    chk("full_wr_rd_empty", 32'(f_empty), 32'd1);

    // write+read on empty, then on count==1
    f_wr = 1'b1; f_rd = 1'b1; f_din = 8'h5A;
    tick();
    chk("empty_wr_rd_underflow", 32'(f_underflow), 32'd1);
    chk("empty_wr_rd_count", 32'(f_count), 32'd1);
    chk("empty_wr_rd_dout", 32'(f_dout), 32'h5A);
    f_din = 8'h6B;
    tick();
    chk("one_wr_rd_count", 32'(f_count), 32'd1);
    chk("one_wr_rd_dout", 32'(f_dout), 32'h6B);
    chk("one_wr_rd_no_underflow", 32'(f_underflow), 32'd0);
    f_wr = 1'b0;
    tick();
    f_rd = 1'b0;
    chk("one_rd_empty", 32'(f_empty), 32'd1);

    // random-gap traffic against a queue scoreboard, enough writes to wrap several times
    m_dout = 8'h6B;
    writes = 0;
    for (int cyc = 0; cyc < 300 && writes < 30; cyc++) begin
      r_wr = ($urandom_range(0, 99) < 65);
      r_rd = ($urandom_range(0, 99) < 55);
      f_din = 8'($urandom);
      f_wr = r_wr; f_rd = r_rd;
      m_empty = (q.size() == 0);
      m_full  = (q.size() == 8);
      m_ar = r_rd && !m_empty;
      m_aw = r_wr && (!m_full || m_ar);
      e_ov = r_wr && m_full && !m_ar;
      e_un = r_rd && m_empty;
      if (m_ar) void'(q.pop_front());
      if (m_aw) begin
        q.push_back(f_din);
        writes++;
      end
      if (q.size() > 0) m_dout = q[0];
      tick();
      chk("rnd_count", 32'(f_count), 32'(q.size()));
      chk("rnd_dout", 32'(f_dout), 32'(m_dout));
      chk("rnd_pulses", {30'd0, f_overflow, f_underflow}, {30'd0, e_ov, e_un});
    end
    chk("rnd_wrap_writes", 32'(writes >= 30), 32'd1);
    f_wr = 1'b0; f_rd = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (q.size() == 0) break;
      void'(q.pop_front());
      if (q.size() > 0) m_dout = q[0];
      tick();
      chk("rnd_drain_dout", 32'(f_dout), 32'(m_dout));
    end
    tick();
    f_rd = 1'b0;
    chk("final_underflow", 32'(f_underflow), 32'd1);
    chk("final_dout_hold", 32'(f_dout), 32'(m_dout));
    tick();
    chk("final_underflow_clear", 32'(f_underflow), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
